// File: rtl/vec_insn_queue_if.sv
// Handshake bundle between the scalar core's vector-dispatch port, the
// instruction queue and the vector decoder.
interface vec_insn_queue_if #(
  parameter int INSN_WIDTH = 32
);
  logic [INSN_WIDTH-1:0] insn_in;
  logic                  insn_in_valid;
  logic                  insn_in_ready;
  logic [INSN_WIDTH-1:0] insn_out;
  logic                  insn_out_valid;
  logic                  decode_ready;

  // Master is the environment (core push side plus decoder pop side).
  modport master (
    output insn_in, insn_in_valid, decode_ready,
    input  insn_in_ready, insn_out, insn_out_valid
  );

  // Slave is the queue itself.
  modport slave (
    input  insn_in, insn_in_valid, decode_ready,
    output insn_in_ready, insn_out, insn_out_valid
  );
endinterface

// File: rtl/vec_insn_queue.sv
// Elastic FIFO of vector instructions between core dispatch and the vector
// decoder; non-vector opcodes are accepted and silently discarded.
module vec_insn_queue #(
  parameter  int INSN_WIDTH = 32,
  parameter  int DEPTH      = 4,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  vec_insn_queue_if.slave   bus,
  output logic [CNT_W-1:0]  count,
  output logic              drop_pulse
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [6:0] OPC_OP_V  = 7'b1010111;
  localparam logic [6:0] OPC_LOAD  = 7'b0000111;
  localparam logic [6:0] OPC_STORE = 7'b0100111;

  function automatic logic is_vec_opcode(input logic [6:0] opc);
    return (opc == OPC_OP_V) || (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

  // Explicit wrap so non-power-of-two depths index only valid entries.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [INSN_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  logic push_hs;
  logic store;
  logic drop;
  logic pop_hs;
  logic full;
  logic empty;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Ready deliberately ignores decode_ready: a full queue stalls even on a
  // same-cycle pop, keeping the ready path free of downstream timing.
  assign bus.insn_in_ready  = ~full & ~flush;
  assign bus.insn_out_valid = ~empty;
  assign bus.insn_out       = mem[rd_ptr];

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    push_hs = 1'b0;
    store   = 1'b0;
    drop    = 1'b0;
    pop_hs  = 1'b0;
    push_hs = bus.insn_in_valid & bus.insn_in_ready;
    if (push_hs) begin
      if (is_vec_opcode(bus.insn_in[6:0])) store = 1'b1;
      else                                 drop  = 1'b1;
    end
    pop_hs = ~empty & bus.decode_ready & ~flush;
  end

  // NOTE: the storage array is reset because insn_out must read 0 out of
  // reset; flush only rewinds pointers and leaves the contents alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (store) begin
      mem[wr_ptr] <= bus.insn_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_pulse <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= drop;
      if (store)  wr_ptr <= ptr_inc(wr_ptr);
      if (pop_hs) rd_ptr <= ptr_inc(rd_ptr);
      case ({store, pop_hs})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
